memory_stage: RTL and testbench

Pipeline MEM stage of the OTTER core, and the producer of the MR_* bus that the writeback stage consumes. It accepts one instruction at a time from the EX/MEM register. For loads and stores it runs a request/acknowledge transaction on the data-memory port, formats load data, and registers the MR_* outputs. It stalls upstream through EX_ready while a memory transaction is outstanding.

---
 rtl/memory_stage.sv | 117 +++++++++++
 tb/tb_memory_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: OTTER MEM stage driving a req/ack data-memory port and producing the MR_* writeback bus
module memory_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EX_valid,
  output logic        EX_ready,
  input  logic [31:0] EX_ir,
  input  logic [31:0] EX_PC_4,
  input  logic [31:0] EX_alu_result,
  input  logic [31:0] EX_rs2,
  input  logic        EX_memRead,
  input  logic        EX_memWrite,
  input  logic [1:0]  EX_rf_wr_sel,
  input  logic        EX_regWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MR_dout2,
  output logic [31:0] MR_alu_result,
  output logic [31:0] MR_ir,
  output logic [31:0] MR_PC_4,
  output logic [1:0]  MR_rf_wr_sel,
  output logic        MR_regWrite,
  output logic        MR_misalign
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, next_state;
  logic [31:0] c_ir, c_pc4, c_alu;
  logic [1:0]  c_sel;
  logic        c_rw, c_rd;
  logic        xfer, mem, mis, go, ack;
  logic [2:0]  f3, c_f3;
  logic [1:0]  a;
  logic [3:0]  be;
  logic [31:0] wdata, sh, fmt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= next_state;
  always_comb next_state = go ? WAIT : ack ? IDLE : state;
  always_comb EX_ready = (state == IDLE);
  always_comb begin
    xfer  = EX_valid && EX_ready;
    mem   = EX_memRead || EX_memWrite;
    f3    = EX_ir[14:12];
    a     = EX_alu_result[1:0];
    mis   = mem && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00));
    go    = xfer && mem && !mis;
    ack   = (state == WAIT) && dmem_ack;
    be    = !EX_memWrite ? 4'b0000 : f3[1:0] == 2'b00 ? 4'b0001 << a :
            f3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = f3[1:0] == 2'b00 ? {4{EX_rs2[7:0]}} : f3[1:0] == 2'b01 ? {2{EX_rs2[15:0]}} : EX_rs2;
    c_f3  = c_ir[14:12];
    sh    = dmem_rdata >> {c_alu[1:0], 3'b000};
    fmt   = c_f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
            c_f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
            c_f3 == 3'b100 ? {24'b0, sh[7:0]} :
            c_f3 == 3'b101 ? {16'b0, sh[15:0]} : sh;
  end
  // dmem_* and MR_* are all registered; a retire (direct or on ack) is the only thing that raises MR_regWrite
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
      MR_dout2      <= '0;
      MR_alu_result <= '0;
      MR_ir         <= '0;
      MR_PC_4       <= '0;
      MR_rf_wr_sel  <= '0;
      MR_regWrite   <= 1'b0;
      MR_misalign   <= 1'b0;
      c_ir          <= '0;
      c_pc4         <= '0;
      c_alu         <= '0;
      c_sel         <= '0;
      c_rw          <= 1'b0;
      c_rd          <= 1'b0;
    end else begin
      MR_regWrite <= 1'b0;
      MR_misalign <= 1'b0;
      if (xfer && !go) begin
        MR_alu_result <= EX_alu_result;
        MR_ir         <= EX_ir;
        MR_PC_4       <= EX_PC_4;
        MR_rf_wr_sel  <= EX_rf_wr_sel;
        MR_dout2      <= '0;
        MR_regWrite   <= EX_regWrite && !mis;
        MR_misalign   <= mis;
      end else if (go) begin
        c_ir       <= EX_ir;
        c_pc4      <= EX_PC_4;
        c_alu      <= EX_alu_result;
        c_sel      <= EX_rf_wr_sel;
        c_rw       <= EX_regWrite;
        c_rd       <= EX_memRead;
        dmem_req   <= 1'b1;
        dmem_we    <= EX_memWrite;
        dmem_addr  <= {EX_alu_result[31:2], 2'b00};
        dmem_be    <= be;
        dmem_wdata <= wdata;
      end else if (ack) begin
        dmem_req      <= 1'b0;
        MR_alu_result <= c_alu;
        MR_ir         <= c_ir;
        MR_PC_4       <= c_pc4;
        MR_rf_wr_sel  <= c_sel;
        MR_dout2      <= c_rd ? fmt : 32'b0;
        MR_regWrite   <= c_rw;
      end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors with a scoreboard queue checked by an independent MR_* monitor
module tb_memory_stage;
  logic        CLK = 0, RST_N = 0;
  logic        EX_valid = 0, EX_memRead = 0, EX_memWrite = 0, EX_regWrite = 0, dmem_ack = 0;
  logic [31:0] EX_ir = 0, EX_PC_4 = 0, EX_alu_result = 0, EX_rs2 = 0, dmem_rdata = 0;
  logic [1:0]  EX_rf_wr_sel = 0;
  logic        EX_ready, dmem_req, dmem_we, MR_regWrite, MR_misalign;
  logic [31:0] dmem_addr, dmem_wdata, MR_dout2, MR_alu_result, MR_ir, MR_PC_4;
  logic [3:0]  dmem_be;
  logic [1:0]  MR_rf_wr_sel;
  typedef struct packed {
    logic [31:0] alu, ir, pc4, dout;
    logic [1:0]  sel;
    logic        rw, mis;
  } mr_t;
  mr_t q[$];
  mr_t got, exp_r;
  logic [31:0] last_pc4 = 0;
  int total = 0, bad = 0;
  always #5 CLK = ~CLK;
  memory_stage dut (
    .CLK(CLK), .RST_N(RST_N), .EX_valid(EX_valid), .EX_ready(EX_ready), .EX_ir(EX_ir),
    .EX_PC_4(EX_PC_4), .EX_alu_result(EX_alu_result), .EX_rs2(EX_rs2), .EX_memRead(EX_memRead),
    .EX_memWrite(EX_memWrite), .EX_rf_wr_sel(EX_rf_wr_sel), .EX_regWrite(EX_regWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .MR_dout2(MR_dout2),
    .MR_alu_result(MR_alu_result), .MR_ir(MR_ir), .MR_PC_4(MR_PC_4), .MR_rf_wr_sel(MR_rf_wr_sel),
    .MR_regWrite(MR_regWrite), .MR_misalign(MR_misalign)
  );
  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, g, e);
    end
  endtask
  // Each instruction uses a unique PC+4, so a change of MR_PC_4 marks a retirement even with regWrite low
  always @(negedge CLK)
    if (!RST_N) last_pc4 = 0;
    else if (MR_regWrite || MR_misalign || MR_PC_4 != last_pc4) begin
      got = {MR_alu_result, MR_ir, MR_PC_4, MR_dout2, MR_rf_wr_sel, MR_regWrite, MR_misalign};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL retire_unexpected pc4=%h rw=%b mis=%b", MR_PC_4, MR_regWrite, MR_misalign);
      end else begin
        exp_r = q.pop_front();
        if (got !== exp_r) begin
          bad++;
          $display("FAIL retire got alu=%h ir=%h pc4=%h dout=%h sel=%0d rw=%b mis=%b exp alu=%h ir=%h pc4=%h dout=%h sel=%0d rw=%b mis=%b",
                   got.alu, got.ir, got.pc4, got.dout, got.sel, got.rw, got.mis,
                   exp_r.alu, exp_r.ir, exp_r.pc4, exp_r.dout, exp_r.sel, exp_r.rw, exp_r.mis);
        end
      end
      last_pc4 = MR_PC_4;
    end
  function automatic mr_t mk(input logic [31:0] alu, ir, pc4, dout, input logic [1:0] sel,
                             input logic rw, mis);
    return {alu, ir, pc4, dout, sel, rw, mis};
  endfunction
  task automatic drive(input logic [31:0] ir, pc4, alu, rs2, input logic rd, wr,
                       input logic [1:0] sel, input logic rw);
    chk("ex_ready_before_issue", EX_ready, 1);
    EX_valid = 1; EX_ir = ir; EX_PC_4 = pc4; EX_alu_result = alu; EX_rs2 = rs2;
    EX_memRead = rd; EX_memWrite = wr; EX_rf_wr_sel = sel; EX_regWrite = rw;
    @(negedge CLK);
    EX_valid = 0;
  endtask
  task automatic nomem(input logic [31:0] ir, pc4, alu, input logic rd, wr,
                       input logic [1:0] sel, input logic rw, erw, emis);
    q.push_back(mk(alu, ir, pc4, 0, sel, erw, emis));
    drive(ir, pc4, alu, 0, rd, wr, sel, rw);
    chk("no_dmem_req", dmem_req, 0);
  endtask
  task automatic memop(input logic [31:0] ir, pc4, alu, rs2, input logic rd, wr,
                       input logic [1:0] sel, input logic rw, input logic [3:0] ebe,
                       input logic [31:0] ewd, rdata, input int dly, input logic [31:0] edout);
    q.push_back(mk(alu, ir, pc4, edout, sel, rw, 0));
    drive(ir, pc4, alu, rs2, rd, wr, sel, rw);
    chk("req_high", dmem_req, 1);
    chk("dmem_addr", dmem_addr, {alu[31:2], 2'b00});
    chk("dmem_be", dmem_be, ebe);
    chk("dmem_we", dmem_we, wr);
    if (wr) chk("dmem_wdata", dmem_wdata, ewd);
    chk("ex_ready_wait", EX_ready, 0);
    repeat (dly) begin
      @(negedge CLK);
      chk("ex_ready_wait", EX_ready, 0);
      chk("req_held", dmem_req, 1);
    end
    dmem_ack = 1; dmem_rdata = rdata;
    @(negedge CLK);
    dmem_ack = 0;
    chk("ex_ready_after_ack", EX_ready, 1);
    chk("req_dropped", dmem_req, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge CLK);
    #2 RST_N = 1;
    @(negedge CLK);
    chk("rst_ex_ready", EX_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_regwrite", MR_regWrite, 0);
    chk("rst_alu", MR_alu_result, 0);
    // ALU ops back-to-back: addi x5 then a nop without regWrite
    nomem(32'h00A30293, 32'h1004, 32'h1234, 0, 0, 2'd3, 1, 1, 0);
    nomem(32'h00000013, 32'h1008, 32'h5678, 0, 0, 2'd3, 0, 0, 0);
    @(negedge CLK);
    // loads: LB, LHU, LW (first-cycle ack)
    memop({17'b0, 3'b000, 5'd6, 7'b0000011}, 32'h2004, 32'h103, 0, 1, 0, 2'd2, 1,
          4'b0000, 0, 32'h80FF1122, 3, 32'hFFFFFF80);
    memop({17'b0, 3'b101, 5'd7, 7'b0000011}, 32'h2008, 32'h102, 0, 1, 0, 2'd2, 1,
          4'b0000, 0, 32'h80010000, 1, 32'h00008001);
    memop({17'b0, 3'b010, 5'd8, 7'b0000011}, 32'h200C, 32'h200, 0, 1, 0, 2'd2, 1,
          4'b0000, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    // stores: SB, SH
    memop({17'b0, 3'b000, 5'd0, 7'b0100011}, 32'h3004, 32'h101, 32'h123456AB, 0, 1, 2'd0, 0,
          4'b0010, 32'hABABABAB, 32'h55555555, 2, 0);
    memop({17'b0, 3'b001, 5'd0, 7'b0100011}, 32'h3008, 32'h102, 32'h0000BEEF, 0, 1, 2'd0, 0,
          4'b1100, 32'hBEEFBEEF, 32'h55555555, 0, 0);
    // misaligned LW, then ALU accepted next cycle, then misaligned SH
    nomem({17'b0, 3'b010, 5'd9, 7'b0000011}, 32'h4004, 32'h102, 1, 0, 2'd2, 1, 0, 1);
    nomem(32'h00100093, 32'h4008, 32'h0001, 0, 0, 2'd3, 1, 1, 0);
    nomem({17'b0, 3'b001, 5'd0, 7'b0100011}, 32'h4010, 32'h105, 0, 1, 2'd0, 0, 0, 1);
    @(negedge CLK);
    // reset in WAIT abandons the load
    drive({17'b0, 3'b010, 5'd10, 7'b0000011}, 32'h5000, 32'h300, 0, 1, 0, 2'd2, 1);
    chk("pre_rst_req", dmem_req, 1);
    RST_N = 0;
    #1;
    chk("async_rst_req", dmem_req, 0);
    chk("async_rst_regwrite", MR_regWrite, 0);
    @(negedge CLK);
    #2 RST_N = 1;
    @(negedge CLK);
    chk("post_rst_ex_ready", EX_ready, 1);
    chk("post_rst_req", dmem_req, 0);
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge CLK);
    dmem_ack = 0;
    chk("stray_ack_req", dmem_req, 0);
    chk("stray_ack_regwrite", MR_regWrite, 0);
    chk("stray_ack_ready", EX_ready, 1);
    nomem(32'h00A30293, 32'h5004, 32'h0042, 0, 0, 2'd3, 1, 1, 0);
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
